// File: rtl/cattrap_pkg.sv
// Shared CatTrap constants: button index map and default debounce time.
// Imported by the button front-end and the game FSM for index decoding.
package cattrap_pkg;

  localparam int unsigned BTN_C   = 0;
  localparam int unsigned BTN_U   = 1;
  localparam int unsigned BTN_D   = 2;
  localparam int unsigned BTN_L   = 3;
  localparam int unsigned BTN_R   = 4;
  localparam int unsigned NUM_BTN = 5;

  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  function automatic logic [NUM_BTN-1:0] btn_mask(input int unsigned idx);
    logic [NUM_BTN-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins (master side) and the conditioner (slave side).
interface btn_conditioner_if #(
  parameter int unsigned NUM_BTN = cattrap_pkg::NUM_BTN
);

  logic [NUM_BTN-1:0] BtnIn;
  logic [NUM_BTN-1:0] BtnLevel;
  logic [NUM_BTN-1:0] BtnPulse;
  logic               AnyPulse;

  modport master (
    output BtnIn,
    input  BtnLevel,
    input  BtnPulse,
    input  AnyPulse
  );

  modport slave (
    input  BtnIn,
    output BtnLevel,
    output BtnPulse,
    output AnyPulse
  );

endinterface

// File: rtl/btn_debounce_one.sv
// Single-button conditioner: 2-flop synchroniser, stable-time counter,
// debounced level and a one-cycle press pulse.
module btn_debounce_one #(
  parameter int unsigned DEBOUNCE_CYCLES = cattrap_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level_o,
  output logic pulse_o,
  output logic pulse_d_o
);

  localparam int unsigned         CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Any cycle matching the current level restarts the stable-time count.
  always_comb begin
    accept  = 1'b0;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      accept  = 1'b1;
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    pulse_d = ~level_q & accept & s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign pulse_d_o = pulse_d;

endmodule

// File: rtl/btn_conditioner.sv
// CatTrap button front-end: one debouncer per button plus a registered
// any-press flag aligned with the per-button pulses.
module btn_conditioner
  import cattrap_pkg::*;
#(
  parameter int unsigned NUM_BTN         = cattrap_pkg::NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic        ClkPort,
  input  logic        ResetN,
  btn_conditioner_if.slave btn
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] pulse;
  logic [NUM_BTN-1:0] pulse_next;
  logic               any_pulse_q, any_pulse_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce_one #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (ClkPort),
      .rst_n    (ResetN),
      .btn_in   (btn.BtnIn[g]),
      .level_o  (level[g]),
      .pulse_o  (pulse[g]),
      .pulse_d_o(pulse_next[g])
    );
  end

  // OR the next-state pulses so AnyPulse lands on the same edge as BtnPulse.
  always_comb begin
    any_pulse_d = |pulse_next;
  end

  always_ff @(posedge ClkPort or negedge ResetN) begin
    if (!ResetN) begin
      any_pulse_q <= 1'b0;
    end else begin
      any_pulse_q <= any_pulse_d;
    end
  end

  assign btn.BtnLevel = level;
  assign btn.BtnPulse = pulse;
  assign btn.AnyPulse = any_pulse_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4 (press latency 5 edges
// after the first sampling edge).
module tb_btn_conditioner;

  localparam int unsigned NB = 5;
  localparam int unsigned DC = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  btn_conditioner_if #(.NUM_BTN(NB)) bif ();

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .ClkPort(clk),
    .ResetN (rst_n),
    .btn    (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step n edges; outputs must equal base, plus bits from edge rise_at on,
  // with a pulse on bits only at edge rise_at (rise_at=0: never).
  task automatic expect_cycles(input string tag, input int n, input int rise_at,
                               input logic [4:0] bits, input logic [4:0] base);
    logic [4:0] exp_level, exp_pulse;
    for (int i = 1; i <= n; i++) begin
      step();
      exp_level = base | ((rise_at != 0 && i >= rise_at) ? bits : 5'h00);
      exp_pulse = (i == rise_at) ? bits : 5'h00;
      check_eq({tag, "_level"}, {3'b0, bif.BtnLevel}, {3'b0, exp_level});
      check_eq({tag, "_pulse"}, {3'b0, bif.BtnPulse}, {3'b0, exp_pulse});
      check_eq({tag, "_any"},   {7'b0, bif.AnyPulse}, {7'b0, |exp_pulse});
    end
  endtask

  // Release everything from a held level; level drops at edge 6, no pulses ever.
  task automatic release_all(input string tag, input logic [4:0] held);
    bif.BtnIn = 5'h00;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_eq({tag, "_rel_level"}, {3'b0, bif.BtnLevel}, {3'b0, (i >= 6) ? 5'h00 : held});
      check_eq({tag, "_rel_pulse"}, {3'b0, bif.BtnPulse}, 8'h00);
      check_eq({tag, "_rel_any"},   {7'b0, bif.AnyPulse}, 8'h00);
    end
  endtask

  initial begin
    logic [5:0] bounce;
    n_checks = 0;
    n_fail   = 0;
    rst_n     = 1'b0;
    bif.BtnIn = 5'h1F;

    // 1: held through reset, then re-debounced after release
    expect_cycles("rst_hold", 4, 0, 5'h00, 5'h00);
    rst_n = 1'b1;
    expect_cycles("rst_release", 12, 6, 5'h1F, 5'h00);
    release_all("t1", 5'h1F);

    // 2: single press held 20 cycles
    bif.BtnIn = 5'h01;
    expect_cycles("press0", 20, 6, 5'h01, 5'h00);
    release_all("t2", 5'h01);

    // 3: 3-cycle glitch on bit 1
    bif.BtnIn = 5'h02;
    expect_cycles("glitch1_hi", 3, 0, 5'h00, 5'h00);
    bif.BtnIn = 5'h00;
    expect_cycles("glitch1_lo", 8, 0, 5'h00, 5'h00);

    // 4: bounce 1,0,1,1,0 then steady 1 on bit 2
    bounce = 6'b10110_1;
    for (int i = 5; i >= 1; i--) begin
      bif.BtnIn = {2'b00, bounce[i], 2'b00};
      expect_cycles("bounce2", 1, 0, 5'h00, 5'h00);
    end
    bif.BtnIn = 5'h04;
    expect_cycles("bounce2_settle", 16, 6, 5'h04, 5'h00);
    release_all("t4", 5'h04);

    // 5: simultaneous press on bits 3 and 4
    bif.BtnIn = 5'h18;
    expect_cycles("dual34", 10, 6, 5'h18, 5'h00);
    release_all("t5", 5'h18);

    // 6: reset mid-count (cnt=2 after edge 4), count restarts from zero
    bif.BtnIn = 5'h01;
    expect_cycles("pre_rst", 4, 0, 5'h00, 5'h00);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_level", {3'b0, bif.BtnLevel}, 8'h00);
    expect_cycles("midrst_hold", 2, 0, 5'h00, 5'h00);
    rst_n = 1'b1;
    expect_cycles("midrst_restart", 10, 6, 5'h01, 5'h00);
    release_all("t6", 5'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
